axis_fifo: RTL and testbench
============================

AXIS_FIFO -- requirements
Module: axis_fifo

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the tdata path.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of entries; it must be a power of two, 2 or more.
Ports:
REQ-003 axis_clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  Asynchronous, active-high reset: asserted when 1, despite the name.
REQ-005 s_axis_tvalid  input  1  Upstream beat valid.
REQ-006 s_axis_tdata  input  DATA_WIDTH  Upstream data.
REQ-007 s_axis_tkeep  input  1  Upstream byte-keep flag, stored with the beat.
REQ-008 s_axis_tlast  input  1  Upstream end-of-packet flag, stored with the beat.
REQ-009 m_axis_tready  input  1  Downstream ready.
REQ-010 m_axis_tvalid  output  1  Downstream beat valid.
REQ-011 m_axis_tdata  output  DATA_WIDTH  Downstream data.
REQ-012 m_axis_tkeep  output  1  Downstream keep flag.
REQ-013 m_axis_tlast  output  1  Downstream last flag.
REQ-014 The block SHALL have only one clock and SHALL have no s_axis_tready output.

Function
REQ-015 Each entry SHALL store {tdata, tkeep, tlast} as one unit, so DATA_WIDTH+2 bits per entry.
REQ-016 The block SHALL keep a write pointer and a read pointer, each log2(DEPTH) bits, and an occupancy count of log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-017 Write: at a rising edge with s_axis_tvalid=1 and count<DEPTH, the block SHALL store the input beat at the write pointer and increment the write pointer modulo DEPTH.
REQ-018 Write while full: with s_axis_tvalid=1 and count==DEPTH, the block SHALL drop the beat silently, with no state change, even if a read occurs in the same cycle.
REQ-019 m_axis_tvalid SHALL equal (count!=0); the FIFO is first-word-fall-through.
REQ-020 m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL combinationally present the entry at the read pointer when count!=0, and SHALL be all zeros when count==0.
REQ-021 Read: at a rising edge with m_axis_tvalid=1 and m_axis_tready=1, the block SHALL increment the read pointer modulo DEPTH.
REQ-022 Latency: a beat written at edge N SHALL appear on the m_axis outputs, with m_axis_tvalid=1, immediately after edge N when the FIFO was empty, so the minimum latency is one cycle.
REQ-023 Simultaneous accepted read and write SHALL leave the count unchanged; a write alone SHALL give count+1; a read alone SHALL give count-1.
REQ-024 Ready asserted while empty SHALL have no effect; the count SHALL never underflow.
REQ-025 Output order SHALL be strict FIFO order, with no loss except the writes dropped under REQ-018.
REQ-026 The m_axis outputs SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-027 s_axis_tdata, s_axis_tkeep and s_axis_tlast SHALL be ignored when s_axis_tvalid=0.

Reset
REQ-028 While resetn=1, regardless of the clock, the write pointer, read pointer and count SHALL be 0.
REQ-029 While resetn=1, m_axis_tvalid=0 and m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL all be 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries.
REQ-031 Storage contents need not be cleared on reset.
REQ-032 The first edge after resetn falls to 0 SHALL operate normally.

Verification
REQ-033 Reset: hold resetn=1 for 5 cycles with random inputs, then release -> m_axis_tvalid=0 and all m_axis outputs 0 throughout.
REQ-034 Overfill then drain:
- Stimulus: write 20 random beats, tkeep=1, tlast=0, m_axis_tready=0; then m_axis_tready=1 for 20 cycles with s_axis_tvalid=0.
- Response: exactly the first 16 beats emerge in order.
- m_axis_tvalid drops after the 16th beat and stays 0.
REQ-035 Fall-through: on an empty FIFO, write 8'hA5 with tlast=1 and tkeep=1 -> the next cycle shows m_axis_tvalid=1, m_axis_tdata=8'hA5, m_axis_tlast=1, m_axis_tkeep=1.
REQ-036 Streaming wrap-around: s_axis_tvalid=1 and m_axis_tready=1 for 40 cycles with an incrementing data pattern -> output equals input delayed by 1 cycle, the count stays at 1, and the pointers wrap twice.
REQ-037 Backpressure stability: fill 3 beats, toggle m_axis_tready 0/1 -> the outputs change only after edges where tready=1.
REQ-038 Reset mid-stream: assert resetn with 10 entries held -> m_axis_tvalid=0 immediately (asynchronous), and after release the FIFO is empty.

Source files
------------

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO storing {tdata, tkeep, tlast} per entry.
// No upstream ready: beats offered while full are discarded.
module axis_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                  axis_clk,
   input  logic                  resetn,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tkeep,
   output logic                  m_axis_tlast
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_WIDTH + 2;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_en, rd_en;
   logic [EW-1:0] head;

   // A full FIFO drops the incoming beat even when a read frees a slot this cycle.
   assign wr_en = s_axis_tvalid && (count_q != FULL);
   assign rd_en = m_axis_tready && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge axis_clk or posedge resetn) begin
      if (resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (wr_en && !resetn) mem_q[wr_ptr_q] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
   end

   assign head = mem_q[rd_ptr_q];

   always_comb begin
      m_axis_tvalid = (count_q != '0);
      m_axis_tdata  = '0;
      m_axis_tkeep  = 1'b0;
      m_axis_tlast  = 1'b0;
      if (m_axis_tvalid) begin
         m_axis_tdata = head[EW-1:2];
         m_axis_tkeep = head[1];
         m_axis_tlast = head[0];
      end
   end

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: queue model checked every cycle plus directed literal checks.
module tb_axis_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          axis_clk = 1'b0;
   logic          resetn   = 1'b1;
   logic          s_axis_tvalid = 1'b0;
   logic [DW-1:0] s_axis_tdata  = '0;
   logic          s_axis_tkeep  = 1'b0;
   logic          s_axis_tlast  = 1'b0;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tvalid;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tkeep;
   logic          m_axis_tlast;

   axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .axis_clk      (axis_clk),
      .resetn        (resetn),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast)
   );

   always #5 axis_clk = ~axis_clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          k;
      logic          l;
   } beat_t;

   beat_t q[$];
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a bounded queue; offers while full are dropped, reads pop when non-empty.
   always @(posedge axis_clk or posedge resetn) begin
      if (resetn) q.delete();
      else begin
         bit do_rd, do_wr;
         beat_t b;
         do_rd = (q.size() != 0) && m_axis_tready;
         do_wr = s_axis_tvalid && (q.size() < DEPTH);
         b = '{d: s_axis_tdata, k: s_axis_tkeep, l: s_axis_tlast};
         if (do_rd) void'(q.pop_front());
         if (do_wr) q.push_back(b);
      end
   end

   always @(negedge axis_clk) begin
      beat_t e;
      e = (q.size() != 0) ? q[0] : '0;
      chk("mdl_valid", 32'(m_axis_tvalid), 32'(q.size() != 0));
      chk("mdl_data",  32'(m_axis_tdata),  32'(e.d));
      chk("mdl_keep",  32'(m_axis_tkeep),  32'(e.k));
      chk("mdl_last",  32'(m_axis_tlast),  32'(e.l));
   end

   // Drive inputs, then step to 2 time units after the next rising edge.
   task automatic cyc(input logic tv, input logic [DW-1:0] d, input logic k,
                      input logic l, input logic tr);
      s_axis_tvalid = tv;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      m_axis_tready = tr;
      @(posedge axis_clk);
      #2;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 4; i++) cyc(1'b0, DW'($urandom), 1'b1, 1'b1, 1'b1);
      chk("drain_empty", 32'(m_axis_tvalid), 32'd0);
   endtask

   logic [DW-1:0] beats [20];
   int            n_out;
   logic [DW+1:0] prev_out;
   logic          prev_rdy;

   initial begin
      // Reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         chk("rst_valid", 32'(m_axis_tvalid), 32'd0);
         chk("rst_outs", 32'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 32'd0);
      end
      resetn = 1'b0;
      cyc(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
      chk("post_rst_valid", 32'(m_axis_tvalid), 32'd0);
      chk("post_rst_outs", 32'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 32'd0);

      // Fall-through
      cyc(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
      s_axis_tvalid = 1'b0;
      chk("ft_valid", 32'(m_axis_tvalid), 32'd1);
      chk("ft_data",  32'(m_axis_tdata),  32'hA5);
      chk("ft_last",  32'(m_axis_tlast),  32'd1);
      chk("ft_keep",  32'(m_axis_tkeep),  32'd1);
      drain();

      // Overfill then drain
      for (int i = 0; i < 20; i++) begin
         beats[i] = DW'($urandom);
         cyc(1'b1, beats[i], 1'b1, 1'b0, 1'b0);
      end
      chk("of_valid", 32'(m_axis_tvalid), 32'd1);
      chk("of_head",  32'(m_axis_tdata),  32'(beats[0]));
      n_out = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_axis_tvalid) begin
            chk("of_order", 32'(m_axis_tdata), 32'(beats[n_out < 20 ? n_out : 19]));
            n_out++;
         end
         cyc(1'b0, DW'($urandom), 1'b0, 1'b0, 1'b1);
      end
      chk("of_count", 32'(n_out), 32'd16);
      chk("of_empty", 32'(m_axis_tvalid), 32'd0);

      // Streaming: output equals the value written at the latest edge
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, DW'(i), 1'b1, 1'(i % 5 == 4), 1'b1);
         chk("st_valid", 32'(m_axis_tvalid), 32'd1);
         chk("st_data",  32'(m_axis_tdata),  32'(i));
      end
      drain();

      // Backpressure stability
      cyc(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
      chk("bp_head", 32'(m_axis_tdata), 32'h11);
      for (int i = 0; i < 6; i++) begin
         prev_out = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
         prev_rdy = 1'(i % 2);
         cyc(1'b0, DW'($urandom), 1'b1, 1'b1, prev_rdy);
         if (!prev_rdy)
            chk("bp_hold", 32'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 32'(prev_out));
      end
      chk("bp_empty", 32'(m_axis_tvalid), 32'd0);

      // Reset mid-stream with 10 entries held
      for (int i = 0; i < 10; i++) cyc(1'b1, DW'(8'h40 + i), 1'b1, 1'b0, 1'b0);
      chk("mr_full10", 32'(m_axis_tdata), 32'h40);
      #1 resetn = 1'b1;
      #1 chk("mr_async", 32'(m_axis_tvalid), 32'd0);
      chk("mr_async_d", 32'(m_axis_tdata), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      resetn = 1'b0;
      cyc(1'b0, 8'h5A, 1'b1, 1'b1, 1'b1);
      chk("mr_empty", 32'(m_axis_tvalid), 32'd0);
      cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      chk("mr_resume_v", 32'(m_axis_tvalid), 32'd1);
      chk("mr_resume_d", 32'(m_axis_tdata), 32'h3C);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
